// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, the slot FSM state type and the output polarity
// helpers used by the seven-segment scanner.
//   NUM_DIGITS  number of multiplexed digits
//   SEG_W       segment lines per digit (a..g, bit0 = a)
//   IDX_W       width of the digit index
//   state_t     slot phase: ST_BLANK (all off) / ST_DRIVE (one digit lit)
//   seg_pol     map "1 = lit" segment bits onto the board polarity
//   dig_pol     map "1 = enabled" digit bits onto the board polarity
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;
  localparam int IDX_W      = 2;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  function automatic logic [SEG_W-1:0] seg_pol(input logic [SEG_W-1:0] lit,
                                               input bit act_lo);
    return act_lo ? ~lit : lit;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] dig_pol(input logic [NUM_DIGITS-1:0] on,
                                                    input bit act_lo);
    return act_lo ? ~on : on;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer: per-digit slot sequencer for the seven-segment scanner.
// Each slot lasts SCAN_DIV cycles: the first BLANK_CYC cycles are ST_BLANK,
// the rest ST_DRIVE. The digit index advances when a slot wraps.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   idx           digit currently owning the slot (0..3)
//   slot_wrap     last cycle of the current slot
//   in_blank      slot is in its blanking phase
//   frame_cap     first cycle of digit 0 blanking: frame capture point
//   state_dbg     current FSM state
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 12500,
  parameter int BLANK_CYC = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [IDX_W-1:0] idx,
  output logic             slot_wrap,
  output logic             in_blank,
  output logic             frame_cap,
  output state_t           state_dbg
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  generate
    if (SCAN_DIV <= BLANK_CYC || BLANK_CYC == 0) begin : g_bad_cfg
      $error("seg7_slot_timer: need 0 < BLANK_CYC < SCAN_DIV (SCAN_DIV=%0d BLANK_CYC=%0d)",
             SCAN_DIV, BLANK_CYC);
    end
  endgenerate

  state_t           state;
  logic [CNT_W-1:0] slot_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_BLANK;
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      // End of slot: next digit (3 wraps to 0 by index width) starts blanked.
      state    <= ST_BLANK;
      slot_cnt <= '0;
      idx      <= idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (slot_cnt == BLANK_LAST) begin
        state <= ST_DRIVE;
      end
    end
  end

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  assign in_blank  = (state == ST_BLANK);
  assign frame_cap = in_blank && (slot_cnt == '0) && (idx == '0);
  assign state_dbg = state;

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed 4-digit seven-segment scanner.
// Captures the 28-bit pre-decoded segment pattern once per frame (start of
// digit 0 blanking) so a CPU write never shows as a torn frame, then drives
// one digit per slot with a blanking gap between digits.
// Optional feature macro: SEG7_DIM_EN adds dim_level and a 16-step PWM dimmer.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   seg_in        digit i pattern at seg_in[7*i+6:7*i], bit0 = seg a, 1 = lit
//   dim_level     brightness 0..15, captured with seg_in (SEG7_DIM_EN only)
//   seg_n         shared segment lines, polarity per SEG_ACT_LO
//   dig_n         digit enables, one-hot when active, polarity per DIG_ACT_LO
//   frame_start   high for the cycle following the capture edge
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV   = 12500,
  parameter int BLANK_CYC  = 64,
  parameter bit SEG_ACT_LO = 1'b1,
  parameter bit DIG_ACT_LO = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
`ifdef SEG7_DIM_EN
  input  logic [3:0]                  dim_level,
`endif
  output logic [SEG_W-1:0]            seg_n,
  output logic [NUM_DIGITS-1:0]       dig_n,
  output logic                        frame_start
);

  logic [IDX_W-1:0] idx;
  logic             slot_wrap;
  logic             in_blank;
  logic             frame_cap;
  state_t           state_dbg;

  seg7_slot_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .idx       (idx),
    .slot_wrap (slot_wrap),
    .in_blank  (in_blank),
    .frame_cap (frame_cap),
    .state_dbg (state_dbg)
  );

  // Timer observability signals kept for debug probing only.
  logic unused_timer;
  assign unused_timer = &{1'b0, slot_wrap, state_dbg};

  logic [NUM_DIGITS*SEG_W-1:0] shadow;
  logic [SEG_W-1:0]            digit_pat;
  logic [SEG_W-1:0]            seg_lit;
  logic [NUM_DIGITS-1:0]       dig_on;

  always_comb begin
    digit_pat   = shadow[SEG_W*int'(idx) +: SEG_W];
    dig_on      = '0;
    dig_on[idx] = 1'b1;
  end

`ifdef SEG7_DIM_EN
  logic [3:0] pwm_cnt;
  logic [3:0] dim_lat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
      dim_lat <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (frame_cap) begin
        dim_lat <= dim_level;
      end
    end
  end

  // Only the segments are gated; the digit enable keeps its normal timing.
  assign seg_lit = (pwm_cnt < dim_lat) ? digit_pat : '0;
`else
  assign seg_lit = digit_pat;
`endif

  // Outputs are decoded from the timer's current state and registered, so
  // segments and digit enable always switch on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow      <= '0;
      seg_n       <= seg_pol('0, SEG_ACT_LO);
      dig_n       <= dig_pol('0, DIG_ACT_LO);
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_cap;
      if (frame_cap) begin
        shadow <= seg_in;
      end
      if (in_blank) begin
        seg_n <= seg_pol('0, SEG_ACT_LO);
        dig_n <= dig_pol('0, DIG_ACT_LO);
      end else begin
        seg_n <= seg_pol(seg_lit, SEG_ACT_LO);
        dig_n <= dig_pol(dig_on, DIG_ACT_LO);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux with SCAN_DIV=16, BLANK_CYC=4, active-low outputs.
module tb_seg7_scan_mux;

  localparam int SD = 16;
  localparam int BC = 4;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [27:0] seg_in = '0;
  logic [3:0]  dim_level = '0;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic        frame_start;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .SCAN_DIV   (SD),
    .BLANK_CYC  (BC),
    .SEG_ACT_LO (1'b1),
    .DIG_ACT_LO (1'b1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seg_in      (seg_in),
`ifdef SEG7_DIM_EN
    .dim_level   (dim_level),
`endif
    .seg_n       (seg_n),
    .dig_n       (dig_n),
    .frame_start (frame_start)
  );

  // scoreboard
  int          checks = 0;
  int          failures = 0;
  int          t = 0;            // clock edges since last reset release
  logic [27:0] exp_q[$];         // frame patterns captured so far
  logic [3:0]  dim_cap = '0;

  task automatic chk(input string tag, input logic [27:0] got, input logic [27:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_seg"}, 28'(seg_n), 28'h7F);
    chk({tag, "_dig"}, 28'(dig_n), 28'hF);
    chk({tag, "_fs"}, 28'(frame_start), 28'h0);
  endtask

  // One clock edge: reference model decides what the registered outputs
  // must show after edge t, from the frame/slot arithmetic alone.
  task automatic tick();
    int          pos, d, off;
    logic [27:0] pat;
    logic [6:0]  lit;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_dig;
    @(posedge clk);
    pos = t % (4 * SD);
    d   = pos / SD;
    off = pos % SD;
    if (pos == 0) begin
      exp_q.push_back(seg_in);
      dim_cap = dim_level;
    end
    pat = exp_q[$];
    lit = pat[7*d +: 7];
`ifdef SEG7_DIM_EN
    if (!((t % 16) < int'(dim_cap))) lit = '0;
`endif
    if (off < BC) begin
      exp_seg = 7'h7F;
      exp_dig = 4'hF;
    end else begin
      exp_seg = ~lit;
      exp_dig = ~(4'b0001 << d);
    end
    #1;
    chk("seg_n", 28'(seg_n), 28'(exp_seg));
    chk("dig_n", 28'(dig_n), 28'(exp_dig));
    chk("frame_start", 28'(frame_start), 28'(pos == 0));
    t++;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    t = 0;
    exp_q.delete();
  endtask

  initial begin
    // Reset held: outputs inactive, then scan from digit 0.
    seg_in    = 28'h0C1_8306;
    dim_level = 4'd4;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    release_reset();

    // Directed pattern, with a mid-frame change at cycle 20 that must wait
    // for the next capture.
    for (int i = 0; i < 3 * 64; i++) begin
      tick();
      if (t == 21) begin
        seg_in    = 28'h5A5_3C3C;
        dim_level = 4'd15;
      end
    end

    // Random patterns changing at random points within frames.
    for (int i = 0; i < 6 * 64; i++) begin
      tick();
      if ($urandom_range(0, 15) == 0) begin
        seg_in    = 28'($urandom());
        dim_level = 4'($urandom_range(0, 15));
      end
    end

    // Reset asserted mid-DRIVE of digit 2: outputs go inactive without a clock.
    while ((t % 64) != 2 * SD + 9) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle("async_reset");
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset_hold");
    seg_in    = 28'($urandom());
    dim_level = 4'd0;
    release_reset();

    for (int i = 0; i < 3 * 64; i++) begin
      tick();
      if ($urandom_range(0, 31) == 0) begin
        seg_in    = 28'($urandom());
        dim_level = 4'($urandom_range(0, 15));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
